data_memory_ctrl: RTL and testbench

Parametrised successor to the single-cycle data memory: a word-organised RAM with configurable depth, a programmable wait-state latency, a busy/done handshake, and byte/halfword/word accesses with sign or zero extension. Sits between the CPU's MEM stage and the storage array. The pipeline issues one request and stalls on `busy` until `done` pulses.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/data_memory_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access-size codes,
// FSM state type, wait-counter width and the sub-word alignment rule.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmemState_t;

    // True when the access cannot be performed at this byte offset
    // (size 11 is never legal).
    function automatic logic isMisaligned(input logic [1:0] offset, input logic [1:0] size);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: merges a sub-word store into the stored
// word and extracts/extends a sub-word load from it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        signExt,
    input  logic [31:0] storedWord,
    input  logic [31:0] storeData,
    output logic [31:0] mergedWord,
    output logic [31:0] readValue
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Select the addressed lane(s) for both the store merge and the load result
    always_comb begin
        mergedWord = storedWord;
        readValue  = storedWord;
        byteSel    = storedWord[{offset, 3'b000} +: 8];
        halfSel    = offset[1] ? storedWord[31:16] : storedWord[15:0];
        case (size)
            SIZE_BYTE: begin
                mergedWord[{offset, 3'b000} +: 8] = storeData[7:0];
                readValue = {{24{signExt & byteSel[7]}}, byteSel};
            end
            SIZE_HALF: begin
                if (offset[1]) begin
                    mergedWord[31:16] = storeData[15:0];
                end else begin
                    mergedWord[15:0] = storeData[15:0];
                end
                readValue = {{16{signExt & halfSel[15]}}, halfSel};
            end
            default: begin
                mergedWord = storeData;
                readValue  = storedWord;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data RAM with programmable wait states and a busy/done
// handshake. Define DMEM_SUBWORD_EN to enable byte/half accesses with
// sign/zero extension; otherwise every access is a word access.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [1:0]  accessSize,
    input  logic        signExt,
    output logic [31:0] readData,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    dmemState_t            state;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [IDX-1:0]        idxLat;
    logic [31:0]           dataLat;
    logic                  isWriteLat;
    logic                  errLat;
    logic [31:0]           mem [DEPTH_WORDS];
    logic [31:0]           storedWord;
    logic [31:0]           writeWord;
    logic [31:0]           loadValue;
    logic                  reqIllegal;
    logic                  request;
    logic                  unusedBits;

    assign request    = memRead | memWrite;
    assign storedWord = mem[idxLat];

`ifdef DMEM_SUBWORD_EN
    logic [1:0] offsetLat;
    logic [1:0] sizeLat;
    logic       signLat;

    // Legality of the request presented this cycle
    always_comb reqIllegal = (memRead & memWrite) | isMisaligned(address[1:0], accessSize);

    // Capture the sub-word attributes alongside the rest of the request
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            offsetLat <= '0;
            sizeLat   <= '0;
            signLat   <= 1'b0;
        end else if (state == IDLE && request) begin
            offsetLat <= address[1:0];
            sizeLat   <= accessSize;
            signLat   <= signExt;
        end
    end

    dmem_lane_align uLaneAlign (
        .offset     (offsetLat),
        .size       (sizeLat),
        .signExt    (signLat),
        .storedWord (storedWord),
        .storeData  (dataLat),
        .mergedWord (writeWord),
        .readValue  (loadValue)
    );

    assign unusedBits = ^address[31:IDX+2];
`else
    // Legality of the request presented this cycle
    always_comb reqIllegal = (memRead & memWrite) | (address[1:0] != 2'b00);

    assign writeWord  = dataLat;
    assign loadValue  = storedWord;
    assign unusedBits = ^{address[31:IDX+2], accessSize, signExt};
`endif

    // Request FSM with registered handshake and load result
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            waitCnt    <= '0;
            idxLat     <= '0;
            dataLat    <= '0;
            isWriteLat <= 1'b0;
            errLat     <= 1'b0;
            readData   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (request) begin
                        idxLat     <= address[IDX+1:2];
                        dataLat    <= writeData;
                        isWriteLat <= memWrite;
                        errLat     <= reqIllegal;
                        busy       <= 1'b1;
                        if (reqIllegal || WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state   <= WAIT;
                            waitCnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt == '0) begin
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    error <= errLat;
                    if (!errLat && !isWriteLat) begin
                        readData <= loadValue;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage array: not reset; a write commits on the completion edge
    always_ff @(posedge clock_in) begin
        if (state == DONE && isWriteLat && !errLat) begin
            mem[idxLat] <= writeWord;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed vector table, hand
// sequences for ignored strobes and mid-operation reset, then randomized
// traffic against a reference memory model. Honours DMEM_SUBWORD_EN.
module tb_data_memory_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAITC = 2;
`ifdef DMEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic [31:0] address  = '0;
    logic [31:0] writeData = '0;
    logic        memWrite = 1'b0;
    logic        memRead  = 1'b0;
    logic [1:0]  accessSize = 2'b10;
    logic        signExt  = 1'b0;
    logic [31:0] readData;
    logic        busy;
    logic        done;
    logic        error;

    int passCount  = 0;
    int checkCount = 0;

    logic [31:0] refMem [DEPTH];
    logic [31:0] lastRead = '0;

    data_memory_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .address    (address),
        .writeData  (writeData),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .accessSize (accessSize),
        .signExt    (signExt),
        .readData   (readData),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        bit          sext;
        bit          expErr;
        logic [31:0] expData;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit modelIllegal(input bit wr, input bit rd, input logic [31:0] a,
                                        input logic [1:0] sz);
        if (wr && rd) return 1'b1;
        if (!SUB) return a[1:0] != 2'b00;
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return a[1:0] != 2'b00;
        return 1'b1;
    endfunction

    function automatic int unsigned wordIndex(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz,
                                              input bit sx);
        logic [31:0] w;
        logic [31:0] v;
        w = refMem[wordIndex(a)];
        if (!SUB || sz == 2'b10 || sz == 2'b11) return w;
        if (sz == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic void modelStore(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] sz);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] mask;
        idx = wordIndex(a);
        if (!SUB || sz == 2'b10 || sz == 2'b11) begin
            refMem[idx] = d;
            return;
        end
        if (sz == 2'b00) begin
            sh   = 8 * a[1:0];
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * a[1];
            mask = 32'hFFFF << sh;
        end
        refMem[idx] = (refMem[idx] & ~mask) | ((d << sh) & mask);
    endfunction

    // One request: present strobes for one edge, then wait (bounded) for done
    task automatic runAccess(input string name, input bit wr, input bit rd,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input bit sx,
                             output int lat, output logic errOut, output logic [31:0] dataOut);
        @(negedge clock_in);
        address = a; writeData = d; memWrite = wr; memRead = rd;
        accessSize = sz; signExt = sx;
        @(negedge clock_in);
        memWrite = 1'b0; memRead = 1'b0;
        address = $urandom; writeData = $urandom;
        chk({name, " busy"}, {31'd0, busy}, 32'd1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock_in);
            if (done) begin
                lat = i;
                break;
            end
        end
        errOut  = error;
        dataOut = readData;
        if (lat < 0) $display("FAIL %s timeout: no done within 40 cycles", name);
        @(negedge clock_in);
        chk({name, " pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    // Run a request and compare against the reference model
    task automatic doModel(input string name, input bit wr, input bit rd,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input bit sx);
        bit          ill;
        int          expLat;
        int          lat;
        logic        e;
        logic [31:0] r;
        ill    = modelIllegal(wr, rd, a, sz);
        expLat = ill ? 1 : int'(WAITC) + 1;
        if (!ill && rd) lastRead = modelLoad(a, sz, sx);
        runAccess(name, wr, rd, a, d, sz, sx, lat, e, r);
        if (!ill && wr) modelStore(a, d, sz);
        chk({name, " latency"}, 32'(lat), 32'(expLat));
        chk({name, " error"}, {31'd0, e}, {31'd0, ill});
        chk({name, " readData"}, r, lastRead);
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] r;
        int          doneCount;
        logic [31:0] oldWord;

        tbl[0]  = '{1, 0, 32'h0C,  32'hFFFF0000, 2'b10, 0, 0, 32'h0};
        tbl[1]  = '{0, 1, 32'h0C,  32'h0,        2'b10, 0, 0, 32'hFFFF0000};
        tbl[2]  = '{1, 0, 32'h10,  32'h11223344, 2'b10, 0, 0, 32'hFFFF0000};
        tbl[3]  = '{1, 0, 32'h11,  32'h000000AA, 2'b00, 0, !SUB, 32'hFFFF0000};
        tbl[4]  = '{0, 1, 32'h10,  32'h0, 2'b10, 0, 0, SUB ? 32'h1122AA44 : 32'h11223344};
        tbl[5]  = '{0, 1, 32'h11,  32'h0, 2'b00, 1, !SUB, SUB ? 32'hFFFFFFAA : 32'h11223344};
        tbl[6]  = '{0, 1, 32'h11,  32'h0, 2'b00, 0, !SUB, SUB ? 32'h000000AA : 32'h11223344};
        tbl[7]  = '{0, 1, 32'h12,  32'h0, 2'b01, 1, !SUB, SUB ? 32'h00001122 : 32'h11223344};
        tbl[8]  = '{0, 1, 32'h0E,  32'h0, 2'b10, 0, 1, SUB ? 32'h00001122 : 32'h11223344};
        tbl[9]  = '{1, 0, 32'h01,  32'hBEEF, 2'b01, 0, 1, SUB ? 32'h00001122 : 32'h11223344};
        tbl[10] = '{1, 1, 32'h10,  32'h55555555, 2'b10, 0, 1, SUB ? 32'h00001122 : 32'h11223344};
        tbl[11] = '{0, 1, 32'h10,  32'h0, 2'b11, 0, SUB, SUB ? 32'h00001122 : 32'h11223344};
        tbl[12] = '{0, 1, 32'h10,  32'h0, 2'b10, 0, 0, SUB ? 32'h1122AA44 : 32'h11223344};
        tbl[13] = '{1, 0, 32'h100, 32'hCAFEF00D, 2'b10, 0, 0, SUB ? 32'h1122AA44 : 32'h11223344};
        tbl[14] = '{0, 1, 32'h000, 32'h0, 2'b10, 0, 0, 32'hCAFEF00D};

        // Reset state, during and after reset
        repeat (3) @(negedge clock_in);
        chk("rst readData", readData, 32'h0);
        chk("rst flags", {29'd0, busy, done, error}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock_in);
        chk("post-rst readData", readData, 32'h0);
        chk("post-rst flags", {29'd0, busy, done, error}, 32'd0);

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            runAccess($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data,
                      tbl[i].size, tbl[i].sext, lat, e, r);
            chk($sformatf("vec%0d latency", i), 32'(lat), tbl[i].expErr ? 32'd1 : 32'(WAITC + 1));
            chk($sformatf("vec%0d error", i), {31'd0, e}, {31'd0, tbl[i].expErr});
            chk($sformatf("vec%0d readData", i), r, tbl[i].expData);
        end
        lastRead = tbl[14].expData;

        // Give every word a known value
        for (int i = 0; i < int'(DEPTH); i++) begin
            doModel("fill", 1'b1, 1'b0, 32'(i * 4), $urandom, 2'b10, 1'b0);
        end

        // Strobes while busy must be ignored: exactly one done
        lastRead = modelLoad(32'h40, 2'b10, 1'b0);
        @(negedge clock_in);
        address = 32'h40; memRead = 1'b1; accessSize = 2'b10; signExt = 1'b0;
        @(negedge clock_in);
        memRead = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy && !done) begin
                memWrite = 1'b1; address = $urandom & 32'h3FC; writeData = $urandom;
            end else begin
                memWrite = 1'b0;
            end
            @(negedge clock_in);
            if (done) doneCount++;
        end
        memWrite = 1'b0;
        chk("ignore done count", 32'(doneCount), 32'd1);
        chk("ignore readData", readData, lastRead);

        // Reset while a write is waiting: target keeps its old value
        oldWord = refMem[32];
        @(negedge clock_in);
        address = 32'h80; writeData = ~oldWord; memWrite = 1'b1; accessSize = 2'b10;
        @(negedge clock_in);
        memWrite = 1'b0;
        @(negedge clock_in);
        reset_n = 1'b0;
        #1;
        chk("midrst readData", readData, 32'h0);
        chk("midrst flags", {29'd0, busy, done, error}, 32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;
        lastRead = '0;
        doneCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_in);
            if (done || busy) doneCount++;
        end
        chk("midrst no completion", 32'(doneCount), 32'd0);
        doModel("midrst readback", 1'b0, 1'b1, 32'h80, 32'h0, 2'b10, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            int unsigned op;
            bit wr;
            bit rd;
            op = $urandom_range(0, 9);
            wr = (op < 4) || (op == 9);
            rd = (op >= 4);
            doModel("rand", wr, rd, 32'($urandom_range(0, 1023)), $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
